// File: rtl/uart_tx_peripheral_if.sv
// Bus bundle for the maxicore32 external bus as seen by one peripheral.
//   address       word address [31:2] from the core
//   data_out      write data from the core
//   data_strobes  byte lane enables; [0] covers data_out[7:0]
//   read / write  bus cycle qualifiers
//   selected      peripheral claims this address (combinational)
//   data_in       read data back to the core (combinational, zero when idle)
// The core drives through the master modport, the peripheral uses slave.
interface uart_tx_peripheral_if;
    logic [31:2] address;
    logic [31:0] data_out;
    logic [3:0]  data_strobes;
    logic        read;
    logic        write;
    logic        selected;
    logic [31:0] data_in;

    modport master (
        output address, data_out, data_strobes, read, write,
        input  selected, data_in
    );

    modport slave (
        input  address, data_out, data_strobes, read, write,
        output selected, data_in
    );
endinterface

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter for the maxicore32 external bus.
// Word 0 (DATA) queues a byte into a FIFO; word 1 (STATUS) reports
// {overflow, count, busy, empty, full} and lets software clear overflow.
// Reads complete in the same cycle because the core has no wait states.
// Ports:
//   clock    system clock, all state changes on the rising edge
//   reset    synchronous active-high reset, abandons any frame in flight
//   bus      slave side of the core bus (address/data/strobes/read/write,
//            selected and data_in driven back combinationally)
//   tx       registered serial output, idles high
//   tx_idle  registered: FIFO empty and transmitter in IDLE
module uart_tx_peripheral #(
    parameter logic [29:0] BASE_ADDRESS    = 30'h0400_0000,
    parameter int          CLOCK_DIVISOR   = 434,
    parameter int          FIFO_DEPTH_LOG2 = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    uart_tx_peripheral_if.slave  bus,
    output logic                 tx,
    output logic                 tx_idle
);

    localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int PTR_W  = FIFO_DEPTH_LOG2;
    localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;
    localparam int BAUD_W = $clog2(CLOCK_DIVISOR);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLOCK_DIVISOR - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // ------------------------------------------------------------------
    // Address decode and bus cycle qualification
    // ------------------------------------------------------------------
    logic selected_c;
    logic data_write;
    logic status_write;
    logic overflow_clear;

    assign selected_c     = (bus.address[31:3] == BASE_ADDRESS[29:1]);
    assign data_write     = selected_c & bus.write & ~bus.address[2] & bus.data_strobes[0];
    assign status_write   = selected_c & bus.write &  bus.address[2];
    assign overflow_clear = status_write & bus.data_strobes[1] & bus.data_out[8];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    tx_state_t          state_reg,   state_next;
    logic [BAUD_W-1:0]  baud_reg,    baud_next;
    logic [2:0]         bit_reg,     bit_next;
    logic [7:0]         shift_reg,   shift_next;
    logic               tx_reg,      tx_next;
    logic               tx_idle_reg, tx_idle_next;
    logic [PTR_W-1:0]   wr_ptr_reg,  wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg,  rd_ptr_next;
    logic [CNT_W-1:0]   count_reg,   count_next;
    logic               overflow_reg, overflow_next;

    logic [7:0]         fifo_mem [DEPTH];
    logic [DEPTH-1:0]   entry_we;
    logic [7:0]         fifo_rd_data;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    assign fifo_full  = (count_reg == CNT_W'(DEPTH));
    assign fifo_empty = (count_reg == '0);

    // A full FIFO still accepts a byte when the transmitter pops in the
    // same cycle, since the slot frees up at the same edge.
    assign push = data_write & (~fifo_full | pop);

    // ------------------------------------------------------------------
    // FIFO storage. The transmitter must load its shift register in the
    // same cycle it decides to pop (to keep frames back-to-back with no
    // idle gap), so the head entry is read combinationally.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) begin
                fifo_mem[i] <= bus.data_out[7:0];
            end
        end
    end

    assign fifo_rd_data = fifo_mem[rd_ptr_reg];

    // ------------------------------------------------------------------
    // Transmit FSM: next state, baud timing, shift register and pop
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        pop        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_rd_data;
                    state_next = ST_START;
                    tx_next    = 1'b0;
                    baud_next  = BAUD_RELOAD;
                end
            end
            ST_START: begin
                if (baud_reg == '0) begin
                    state_next = ST_DATA;
                    tx_next    = shift_reg[0];
                    bit_next   = 3'd0;
                    baud_next  = BAUD_RELOAD;
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_reg == '0) begin
                    baud_next = BAUD_RELOAD;
                    if (bit_reg == 3'd7) begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_reg == '0) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit.
                        pop        = 1'b1;
                        shift_next = fifo_rd_data;
                        state_next = ST_START;
                        tx_next    = 1'b0;
                        baud_next  = BAUD_RELOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and sticky overflow
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_next   = wr_ptr_reg + PTR_W'(push);
        rd_ptr_next   = rd_ptr_reg + PTR_W'(pop);
        count_next    = count_reg + CNT_W'(push) - CNT_W'(pop);
        overflow_next = overflow_reg;
        if (overflow_clear) begin
            overflow_next = 1'b0;
        end
        if (data_write && fifo_full && !pop) begin
            overflow_next = 1'b1;
        end
    end

    assign tx_idle_next = (state_next == ST_IDLE) && (count_next == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            tx_idle_reg  <= 1'b1;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            tx_idle_reg  <= tx_idle_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and outputs
    // ------------------------------------------------------------------
    logic        busy;
    logic [31:0] status_word;

    assign busy        = (state_reg != ST_IDLE);
    assign status_word = {23'b0, overflow_reg, 5'(count_reg), busy, fifo_empty, fifo_full};

    assign bus.selected = selected_c;
    assign bus.data_in  = (selected_c && bus.read && bus.address[2]) ? status_word : 32'h0;

    assign tx      = tx_reg;
    assign tx_idle = tx_idle_reg;

    // Upper data bits and lanes are not part of the register map.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.data_out[31:9], bus.data_strobes[3:2]};

endmodule
